nonce_scheduler: RTL and testbench



---
 rtl/sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 30 +++
 rtl/nonce_scheduler.sv | 193 +++++++++++++++++++
 tb/tb_nonce_scheduler.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sched_pkg.sv
// Shared types and sizing helpers for the nonce scheduler and its arbiter.
package sched_pkg;

  localparam int unsigned DEF_NUM_NONCES = 16;
  localparam int unsigned DEF_NUM_CORES  = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FINISH = 2'd2
  } state_e;

  // Counters must hold the terminal value NUM_NONCES without wrapping.
  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr_i, wrapping, for the first request.
module rr_arbiter
  import sched_pkg::*;
#(
  parameter int unsigned N = DEF_NUM_CORES
) (
  input  logic [N-1:0]              req_i,
  input  logic [idx_width(N)-1:0]   ptr_i,
  output logic [N-1:0]              grant_c,
  output logic                      grant_valid_c
);

  localparam int unsigned IDX_W = idx_width(N);

  logic [IDX_W-1:0] idx;

  always_comb begin
    grant_c       = '0;
    grant_valid_c = 1'b0;
    idx           = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = IDX_W'((32'(ptr_i) + k) % N);
      if (!grant_valid_c && req_i[idx]) begin
        grant_c[idx]  = 1'b1;
        grant_valid_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/nonce_scheduler.sv
// Hands nonces to idle hash cores and funnels their results into one memory write port.
module nonce_scheduler
  import sched_pkg::*;
#(
  parameter int unsigned NUM_NONCES = DEF_NUM_NONCES,
  parameter int unsigned NUM_CORES  = DEF_NUM_CORES,
  parameter int unsigned ADDR_W     = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         output_addr,
  output logic                      done,
  input  logic [NUM_CORES-1:0]      core_idle,
  output logic [NUM_CORES-1:0]      core_start,
  output logic [31:0]               core_nonce,
  input  logic [NUM_CORES-1:0]      core_valid,
  input  logic [32*NUM_CORES-1:0]   core_hash,
  output logic [NUM_CORES-1:0]      core_ack,
  output logic                      mem_we,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic [31:0]               mem_write_data
);

  localparam int unsigned CNT_W = cnt_width(NUM_NONCES);
  localparam int unsigned IDX_W = idx_width(NUM_CORES);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [CNT_W-1:0]     next_nonce_q, next_nonce_d;
  logic [CNT_W-1:0]     written_q, written_d;
  logic [NUM_CORES-1:0] assigned_q, assigned_d;
  logic [CNT_W-1:0]     nonce_tab_q [NUM_CORES];
  logic [CNT_W-1:0]     nonce_tab_d [NUM_CORES];
  logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic                 done_q, done_d;
  logic                 mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [31:0]          mem_wdata_q, mem_wdata_d;
  logic [NUM_CORES-1:0] core_start_q, core_start_d;
  logic [NUM_CORES-1:0] core_ack_q, core_ack_d;
  logic [31:0]          core_nonce_q, core_nonce_d;

  logic [31:0]          hash_w [NUM_CORES];
  logic                 disp_hit;
  logic [IDX_W-1:0]     disp_idx;
  logic [NUM_CORES-1:0] grant_c;
  logic                 grant_valid_c;
  logic [IDX_W-1:0]     gnt_idx;

  always_comb begin
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      hash_w[i] = core_hash[32*i +: 32];
    end
  end

  // Lowest-index idle, unassigned core gets the next nonce while any remain.
  always_comb begin
    disp_hit = 1'b0;
    disp_idx = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (!disp_hit && core_idle[i] && !assigned_q[i]) begin
        disp_hit = 1'b1;
        disp_idx = IDX_W'(i);
      end
    end
    if (state_q != RUN || next_nonce_q >= CNT_W'(NUM_NONCES)) begin
      disp_hit = 1'b0;
    end
  end

  // Only cores holding an outstanding nonce may request the write port.
  rr_arbiter #(.N(NUM_CORES)) u_collect_arb (
    .req_i         (core_valid & assigned_q),
    .ptr_i         (rr_ptr_q),
    .grant_c       (grant_c),
    .grant_valid_c (grant_valid_c)
  );

  always_comb begin
    gnt_idx = '0;
    for (int unsigned i = 0; i < NUM_CORES; i++) begin
      if (grant_c[i]) begin
        gnt_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    next_nonce_d = next_nonce_q;
    written_d    = written_q;
    assigned_d   = assigned_q;
    nonce_tab_d  = nonce_tab_q;
    rr_ptr_d     = rr_ptr_q;
    done_d       = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    core_start_d = '0;
    core_ack_d   = '0;
    core_nonce_d = core_nonce_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d       = output_addr;
          next_nonce_d = '0;
          written_d    = '0;
          assigned_d   = '0;
          rr_ptr_d     = '0;
          state_d      = RUN;
        end
      end

      RUN: begin
        if (disp_hit) begin
          core_start_d[disp_idx] = 1'b1;
          core_nonce_d           = 32'(next_nonce_q);
          nonce_tab_d[disp_idx]  = next_nonce_q;
          assigned_d[disp_idx]   = 1'b1;
          next_nonce_d           = next_nonce_q + CNT_W'(1);
        end
        // Dispatch and grant never target the same core: one needs assigned=0, the other assigned=1.
        if (grant_valid_c) begin
          mem_we_d            = 1'b1;
          mem_addr_d          = base_q + ADDR_W'(nonce_tab_q[gnt_idx]);
          mem_wdata_d         = hash_w[gnt_idx];
          core_ack_d[gnt_idx] = 1'b1;
          assigned_d[gnt_idx] = 1'b0;
          rr_ptr_d            = IDX_W'((32'(gnt_idx) + 32'd1) % NUM_CORES);
          written_d           = written_q + CNT_W'(1);
          if (written_q == CNT_W'(NUM_NONCES - 1)) begin
            state_d = FINISH;
          end
        end
      end

      FINISH: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      base_q       <= '0;
      next_nonce_q <= '0;
      written_q    <= '0;
      assigned_q   <= '0;
      rr_ptr_q     <= '0;
      done_q       <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      core_start_q <= '0;
      core_ack_q   <= '0;
      core_nonce_q <= '0;
      for (int unsigned i = 0; i < NUM_CORES; i++) begin
        nonce_tab_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      base_q       <= base_d;
      next_nonce_q <= next_nonce_d;
      written_q    <= written_d;
      assigned_q   <= assigned_d;
      rr_ptr_q     <= rr_ptr_d;
      done_q       <= done_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      core_start_q <= core_start_d;
      core_ack_q   <= core_ack_d;
      core_nonce_q <= core_nonce_d;
      nonce_tab_q  <= nonce_tab_d;
    end
  end

  assign done           = done_q;
  assign core_start     = core_start_q;
  assign core_nonce     = core_nonce_q;
  assign core_ack       = core_ack_q;
  assign mem_we         = mem_we_q;
  assign mem_addr       = mem_addr_q;
  assign mem_write_data = mem_wdata_q;

endmodule

// File: tb/tb_nonce_scheduler.sv
// Bench for nonce_scheduler: behavioural hash-core array plus a cycle-level expectation model.
module tb_nonce_scheduler;

  localparam int unsigned NN = 16;
  localparam int unsigned NC = 4;
  localparam int unsigned AW = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              start;
  logic [AW-1:0]     output_addr;
  logic              done;
  logic [NC-1:0]     core_idle;
  logic [NC-1:0]     core_start;
  logic [31:0]       core_nonce;
  logic [NC-1:0]     core_valid;
  logic [32*NC-1:0]  core_hash;
  logic [NC-1:0]     core_ack;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_write_data;

  always #5 clk = ~clk;

  nonce_scheduler #(.NUM_NONCES(NN), .NUM_CORES(NC), .ADDR_W(AW)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .output_addr    (output_addr),
    .done           (done),
    .core_idle      (core_idle),
    .core_start     (core_start),
    .core_nonce     (core_nonce),
    .core_valid     (core_valid),
    .core_hash      (core_hash),
    .core_ack       (core_ack),
    .mem_we         (mem_we),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data)
  );

  int n_chk = 0;
  int n_fail = 0;

  // Core-array knobs: hold hides a finished result, stall hides idleness, spur fakes a valid.
  logic [NC-1:0] hold_m, stall_m, spur_m;
  int            lat_fix;

  bit            c_busy [NC];
  bit            c_rdy  [NC];
  int            c_cnt  [NC];
  int unsigned   c_non  [NC];

  int            phase;
  int unsigned   nxt, wr_cnt, rr;
  logic [15:0]   base_m;
  int            obs_wr, dut_done_cnt, exp_done_cnt;

  logic [NC-1:0] e_start, e_ack;
  logic          e_done;
  logic [31:0]   e_nonce, e_data;
  logic [15:0]   e_addr;

  function automatic logic [31:0] hfn(input int unsigned n);
    return (32'(n) * 32'h9E3779B1) ^ 32'hA5A5A5A5;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit all_rdy(input logic [NC-1:0] mask);
    for (int i = 0; i < NC; i++)
      if (mask[i] && !(c_busy[i] && c_rdy[i])) return 1'b0;
    return 1'b1;
  endfunction

  // One clock: drive cores, predict the coming edge, compare after it, advance the model.
  task automatic tick();
    int s, g;
    logic [NC-1:0] req;
    for (int i = 0; i < NC; i++) begin
      core_idle[i]  = !c_busy[i] && !stall_m[i];
      core_valid[i] = (c_busy[i] && c_rdy[i] && !hold_m[i]) || spur_m[i];
      core_hash[32*i +: 32] = (c_busy[i] && c_rdy[i]) ? hfn(c_non[i]) : (32'hBAD0_0000 | 32'(i));
    end
    e_start = '0; e_ack = '0; e_done = 1'b0;
    if (reset) begin
      e_nonce = '0; e_addr = '0; e_data = '0;
    end else if (phase == 1) begin
      s = -1;
      if (nxt < NN)
        for (int i = 0; i < NC; i++)
          if (s < 0 && core_idle[i] && !c_busy[i]) s = i;
      if (s >= 0) begin
        e_start[s] = 1'b1;
        e_nonce = 32'(nxt);
      end
      for (int i = 0; i < NC; i++) req[i] = core_valid[i] && c_busy[i];
      g = -1;
      for (int k = 0; k < NC; k++)
        if (g < 0 && req[(int'(rr) + k) % NC]) g = (int'(rr) + k) % NC;
      if (g >= 0) begin
        e_ack[g] = 1'b1;
        e_addr = base_m + 16'(c_non[g]);
        e_data = hfn(c_non[g]);
      end
    end else if (phase == 2) begin
      e_done = 1'b1;
    end

    @(negedge clk);
    chk("core_start", 32'(core_start), 32'(e_start));
    chk("core_ack", 32'(core_ack), 32'(e_ack));
    chk("mem_we", 32'(mem_we), 32'(e_ack != '0));
    chk("done", 32'(done), 32'(e_done));
    chk("core_nonce", core_nonce, e_nonce);
    chk("mem_addr", 32'(mem_addr), 32'(e_addr));
    chk("mem_write_data", mem_write_data, e_data);
    if (mem_we === 1'b1) obs_wr++;
    if (done === 1'b1) dut_done_cnt++;

    if (reset) begin
      phase = 0; nxt = 0; wr_cnt = 0; rr = 0;
      for (int i = 0; i < NC; i++) begin c_busy[i] = 0; c_rdy[i] = 0; end
    end else begin
      for (int i = 0; i < NC; i++)
        if (c_busy[i] && !c_rdy[i]) begin
          c_cnt[i]--;
          if (c_cnt[i] <= 0) c_rdy[i] = 1;
        end
      case (phase)
        0: if (start) begin
             phase = 1; nxt = 0; wr_cnt = 0; rr = 0; base_m = output_addr;
           end
        1: begin
             for (int i = 0; i < NC; i++) begin
               if (e_ack[i]) begin
                 c_busy[i] = 0; c_rdy[i] = 0;
                 rr = (i + 1) % NC;
                 wr_cnt++;
               end
               if (e_start[i]) begin
                 c_busy[i] = 1; c_rdy[i] = 0; c_non[i] = nxt; nxt++;
                 c_cnt[i] = (lat_fix != 0) ? lat_fix : int'($urandom_range(2, 7));
               end
             end
             if (wr_cnt == NN) phase = 2;
           end
        default: begin phase = 0; exp_done_cnt++; end
      endcase
    end
  endtask

  task automatic start_run(input logic [15:0] b);
    output_addr = b;
    start = 1'b1;
    obs_wr = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run_end(input int budget);
    int k = 0;
    while (phase != 0 && k < budget) begin tick(); k++; end
    chk("run_timeout", 32'(phase), 32'd0);
    chk("write_count", 32'(obs_wr), 32'(NN));
    chk("done_count", 32'(dut_done_cnt), 32'(exp_done_cnt));
  endtask

  task automatic wait_rdy(input logic [NC-1:0] mask, input int budget);
    int k = 0;
    while (!all_rdy(mask) && k < budget) begin tick(); k++; end
    chk("rdy_timeout", 32'(all_rdy(mask)), 32'd1);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; output_addr = '0;
    hold_m = '0; stall_m = '0; spur_m = '0; lat_fix = 0;
    phase = 0; nxt = 0; wr_cnt = 0; rr = 0; base_m = '0;
    obs_wr = 0; dut_done_cnt = 0; exp_done_cnt = 0;
    e_nonce = '0; e_addr = '0; e_data = '0;
    for (int i = 0; i < NC; i++) begin c_busy[i] = 0; c_rdy[i] = 0; c_cnt[i] = 0; c_non[i] = 0; end

    // Reset state
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();

    // Single usable core, fixed 5-cycle latency: writes land in nonce order at 0x0010..0x001F
    stall_m = 4'b1110; lat_fix = 5;
    start_run(16'h0010);
    wait_run_end(400);
    repeat (2) tick();

    // All four results released together: grants 0,1,2,3 on consecutive edges, twice
    stall_m = '0; lat_fix = 0; hold_m = 4'hF;
    start_run(16'h0400);
    for (int rep = 0; rep < 2; rep++) begin
      wait_rdy(4'hF, 100);
      hold_m = '0;
      for (int k = 0; k < NC; k++) begin
        tick();
        chk("contend_order", 32'(core_ack), 32'(1) << k);
      end
      hold_m = (rep == 0) ? 4'hF : 4'h0;
    end
    wait_run_end(600);
    repeat (2) tick();

    // Address wrap, start held for the whole run and output_addr changed after acceptance
    output_addr = 16'hFFF8; start = 1'b1; obs_wr = 0;
    tick();
    output_addr = 16'h1234;
    for (int k = 0; k < 600 && phase == 1; k++) begin
      stall_m = 4'($urandom_range(0, 15)) & 4'b0110;
      tick();
    end
    stall_m = '0; start = 1'b0;
    wait_run_end(10);
    repeat (3) tick();

    // Reset after the seventh write, then a fresh run restarts from nonce 0
    start_run(16'h0100);
    for (int k = 0; k < 300 && wr_cnt < 7; k++) tick();
    chk("pre_reset_writes", 32'(obs_wr), 32'd7);
    reset = 1'b1;
    tick();
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_core_start", 32'(core_start), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    reset = 1'b0;
    tick();
    start_run(16'h0200);
    tick();
    chk("restart_nonce0", 32'(core_start), 32'd1);
    wait_run_end(600);

    // Core 2 acked while core 3 becomes idle: same-edge dispatch; core 1 spurious throughout
    stall_m = 4'b1010; spur_m = 4'b0010; hold_m = 4'b0101;
    start_run(16'h0800);
    wait_rdy(4'b0101, 100);
    hold_m = 4'b0001; stall_m = 4'b0010;
    tick();
    chk("same_cycle_ack", 32'(core_ack), 32'b0100);
    chk("same_cycle_start", 32'(core_start), 32'b1000);
    chk("same_cycle_we", 32'(mem_we), 32'd1);
    hold_m = '0;
    wait_run_end(600);
    spur_m = 4'hF;
    repeat (4) tick();
    spur_m = '0; stall_m = '0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
